// File: rtl/falling_edge_sipo_deserializer_if.sv
// Bundles the serial input, the word handoff handshake and the status flags
// of the falling-edge deserializer.
interface falling_edge_sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             ser_in;
  logic             ser_en;
  logic             start;
  logic             par_ready;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output ser_in, ser_en, start, par_ready,
    input  par_out, par_valid, busy, overrun
  );

  modport slave (
    input  ser_in, ser_en, start, par_ready,
    output par_out, par_valid, busy, overrun
  );
endinterface

// File: rtl/falling_edge_sipo_deserializer.sv
// Serial-in/parallel-out deserializer clocked on the falling edge of clk,
// assembling WIDTH enabled bits into a word handed off via valid/ready.
module falling_edge_sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic async_reset_n,
  falling_edge_sipo_deserializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             par_valid_q, par_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] shift_with_bit;
  logic             last_bit;

  // Each bit is written straight to its final position; equivalent to
  // shifting, since the register is cleared at the start of every word.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign bit_idx = CW'(WIDTH - 1) - cnt_q;
    end else begin : g_lsb_first
      assign bit_idx = cnt_q;
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    shift_with_bit          = shift_q;
    shift_with_bit[bit_idx] = bus.ser_in;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end

      SHIFT: begin
        if (bus.ser_en) begin
          shift_d = shift_with_bit;
          if (last_bit) begin
            par_out_d   = shift_with_bit;
            par_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      HOLD: begin
        if (bus.par_ready) begin
          par_valid_d = 1'b0;
          if (bus.start) begin
            // Back-to-back handoff: the next word begins on the same edge.
            state_d = SHIFT;
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.start) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        shift_d     = '0;
        par_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(negedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_falling_edge_sipo_deserializer.sv
// Drives an MSB-first and an LSB-first deserializer with shared stimulus and
// checks both against a bit-queue reference model on every falling edge.
module tb_falling_edge_sipo_deserializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic async_reset_n = 1'b0;
  logic ser_in = 1'b0;
  logic ser_en = 1'b0;
  logic start = 1'b0;
  logic par_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  falling_edge_sipo_deserializer_if #(.WIDTH(W)) if_m ();
  falling_edge_sipo_deserializer_if #(.WIDTH(W)) if_l ();

  assign if_m.ser_in    = ser_in;
  assign if_m.ser_en    = ser_en;
  assign if_m.start     = start;
  assign if_m.par_ready = par_ready;
  assign if_l.ser_in    = ser_in;
  assign if_l.ser_en    = ser_en;
  assign if_l.start     = start;
  assign if_l.par_ready = par_ready;

  falling_edge_sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .async_reset_n(async_reset_n), .bus(if_m.slave)
  );
  falling_edge_sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .async_reset_n(async_reset_n), .bus(if_l.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting for start, 1 = collecting bits, 2 = holding word
  int       m_mode = 0;
  bit       m_bits[$];
  bit [7:0] m_word_m = '0;
  bit [7:0] m_word_l = '0;
  bit       m_valid = 1'b0;
  bit       m_over = 1'b0;

  always @(negedge clk) begin
    if (!async_reset_n) begin
      m_mode = 0; m_bits.delete(); m_word_m = '0; m_word_l = '0;
      m_valid = 1'b0; m_over = 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_bits.delete(); end
        1: if (ser_en) begin
          m_bits.push_back(ser_in);
          if (m_bits.size() == W) begin
            m_word_m = '0; m_word_l = '0;
            for (int i = 0; i < W; i++) begin
              if (m_bits[i]) begin
                m_word_m = m_word_m | (8'd1 << (W - 1 - i));
                m_word_l = m_word_l | (8'd1 << i);
              end
            end
            m_valid = 1'b1;
            m_mode = 2;
          end
        end
        default: begin
          if (par_ready) begin
            m_valid = 1'b0;
            if (start) begin m_mode = 1; m_bits.delete(); end
            else m_mode = 0;
          end else if (start) begin
            m_over = 1'b1;
          end
        end
      endcase
    end
    #2;
    chk("m_par_out", if_m.par_out, m_word_m);
    chk("l_par_out", if_l.par_out, m_word_l);
    chk("m_par_valid", if_m.par_valid, m_valid);
    chk("l_par_valid", if_l.par_valid, m_valid);
    chk("m_busy", if_m.busy, m_mode != 0);
    chk("l_busy", if_l.busy, m_mode != 0);
    chk("m_overrun", if_m.overrun, m_over);
    chk("l_overrun", if_l.overrun, m_over);
  end

  // One clock: inputs change just after the rising edge, return after the falling edge.
  task automatic cyc(input logic s, input logic en, input logic d, input logic rdy);
    @(posedge clk);
    #1;
    start = s; ser_en = en; ser_in = d; par_ready = rdy;
    @(negedge clk);
    #3;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap_after, input int gap_len);
    for (int i = 0; i < W; i++) begin
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) cyc(1'b0, 1'b0, g[0], 1'b0);
      end
      if (i == W - 1) chk("valid_before_last_bit", if_m.par_valid, 1'b0);
      cyc(1'b0, 1'b1, w[W - 1 - i], 1'b0);
    end
    chk("valid_on_last_bit", if_m.par_valid, 1'b1);
  endtask

  task automatic reset_now();
    @(posedge clk);
    #1;
    async_reset_n = 1'b0;
    #1;
    chk("rst_m_par_out", if_m.par_out, 8'h00);
    chk("rst_l_par_out", if_l.par_out, 8'h00);
    chk("rst_par_valid", if_m.par_valid, 1'b0);
    chk("rst_busy", if_m.busy, 1'b0);
    chk("rst_l_busy", if_l.busy, 1'b0);
    chk("rst_overrun", if_m.overrun, 1'b0);
    @(negedge clk);
    #3;
    @(posedge clk);
    #1;
    async_reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_par_out", if_m.par_out, 8'h00);
    @(posedge clk);
    #1;
    async_reset_n = 1'b1;

    // Mid-word reset, then ser_en activity without start
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("busy_mid_word", if_m.busy, 1'b1);
    reset_now();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, i[0], 1'b1);
    chk("no_valid_without_start", if_m.par_valid, 1'b0);

    // Edge discipline: start raised after a rising edge takes effect at the falling edge
    @(posedge clk);
    #1;
    start = 1'b1;
    #2;
    chk("no_change_before_fall", if_m.busy, 1'b0);
    @(negedge clk);
    #3;
    chk("busy_after_fall", if_m.busy, 1'b1);

    // Continuous capture
    send_word(8'hB2, 99, 0);
    chk("msb_word_b2", if_m.par_out, 8'hB2);
    chk("lsb_word_4d", if_l.par_out, 8'h4D);
    chk("model_pins_b2", m_word_m, 8'hB2);
    chk("model_pins_4d", m_word_l, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("handoff_valid", if_m.par_valid, 1'b0);
    chk("handoff_idle", if_m.busy, 1'b0);
    chk("retained_word", if_m.par_out, 8'hB2);

    // Gapped capture: three disabled edges after bit 4
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hB2, 4, 3);
    chk("gapped_word", if_m.par_out, 8'hB2);

    // Overrun in HOLD, then back-to-back start with ready
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("overrun_set", if_m.overrun, 1'b1);
    chk("overrun_word_kept", if_m.par_out, 8'hB2);
    chk("overrun_valid_kept", if_m.par_valid, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b_valid_low", if_m.par_valid, 1'b0);
    chk("b2b_busy", if_m.busy, 1'b1);
    send_word(8'h5A, 99, 0);
    chk("b2b_word_5a", if_m.par_out, 8'h5A);
    chk("b2b_lsb_5a", if_l.par_out, 8'h5A);
    chk("overrun_sticky", if_m.overrun, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset_now();
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
